// File: rtl/hog_bin_pipe_if.sv
// Stream interface for the gradient-binning pipe: gradient pairs in, magnitude/bin out.
interface hog_bin_pipe_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH:0]   in_gx;
  logic signed [DATA_WIDTH:0]   in_gy;
  logic                         in_border;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic        [DATA_WIDTH-1:0] out_mag;
  logic        [4:0]            out_bin;
  logic                         out_sat;
  logic                         out_last;

  // The binning stage itself.
  modport slave (
    input  in_valid, in_gx, in_gy, in_border, in_last, out_ready,
    output in_ready, out_valid, out_mag, out_bin, out_sat, out_last
  );

  // Upstream producer plus downstream consumer, as seen by whoever drives the stage.
  modport master (
    output in_valid, in_gx, in_gy, in_border, in_last, out_ready,
    input  in_ready, out_valid, out_mag, out_bin, out_sat, out_last
  );
endinterface

// File: rtl/hog_bin_pipe.sv
// Gradient-binning pipe: 3 register stages turning (Gx, Gy) into a saturated
// magnitude and an orientation bin. Stage 1 folds the vector into the upper
// half plane, stage 2 does the tangent-threshold binning and the magnitude,
// stage 3 is the output register. Border pixels are dropped at the input
// unless they carry the frame-end marker, in which case they become a zero token.
module hog_bin_pipe #(
  parameter int DATA_WIDTH    = 8,
  parameter int SIGNED_ORIENT = 0,
  parameter int MAG_MODE      = 0
) (
  input  logic          clk,
  input  logic          rst,
  hog_bin_pipe_if.slave bus
);
  localparam int STAGES = 3;
  localparam int AW     = DATA_WIDTH + 1;   // absolute component width
  localparam int MW     = DATA_WIDTH + 2;   // signed working / raw magnitude width
  localparam int CW     = DATA_WIDTH + 12;  // tangent comparison width
  localparam logic [MW-1:0] MAG_MAX = MW'((1 << DATA_WIDTH) - 1);

  logic [STAGES:1] vld_pipe;
  logic            en;

  // Whole pipe moves together; it only freezes when a result is waiting on the output.
  assign en           = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = vld_pipe[STAGES];

  // ---------------- stage 1: fold into upper half plane ----------------
  logic signed [MW-1:0] gx_e, gy_e, rx, ry;
  logic                 h_c;
  logic [AW-1:0]        ax_c, ay_c;

  // Reflect through the origin when the vector points into the lower half plane.
  always_comb begin
    gx_e = MW'(bus.in_gx);
    gy_e = MW'(bus.in_gy);
    h_c  = (gy_e < 0) || (gy_e == 0 && gx_e < 0);
    rx   = h_c ? -gx_e : gx_e;
    ry   = h_c ? -gy_e : gy_e;
    ax_c = rx[MW-1] ? AW'(-rx) : AW'(rx);
    ay_c = AW'(ry);
  end

  logic          xneg1, h1, brd1, last1;
  logic [AW-1:0] ax1, ay1;

  // Stage-1 register: folded components plus the tags that travel with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xneg1 <= 1'b0;
      h1    <= 1'b0;
      ax1   <= '0;
      ay1   <= '0;
      brd1  <= 1'b0;
      last1 <= 1'b0;
    end else if (en) begin
      xneg1 <= rx[MW-1];
      h1    <= h_c;
      ax1   <= ax_c;
      ay1   <= ay_c;
      brd1  <= bus.in_border;
      last1 <= bus.in_last;
    end
  end

  // Valid shift register; a non-final border pixel enters as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (en)
      vld_pipe <= {vld_pipe[STAGES-1:1],
                   bus.in_valid && (!bus.in_border || bus.in_last)};
  end

  // ---------------- stage 2: orientation and magnitude ----------------
  logic [CW-1:0]         ys;
  logic [3:0]            ge;
  logic [2:0]            s_c;
  logic [3:0]            b_c;
  logic [4:0]            bin_c;
  logic [MW-1:0]         a_c, y_c, mx, mn, mag_raw;
  logic                  sat_c;
  logic [DATA_WIDTH-1:0] mag_c;

  // Sector count against tan(20/40/60/80 deg) in Q8, then fold back for negative x.
  always_comb begin
    ys    = CW'(ay1) << 8;
    ge[0] = ys >= CW'(ax1) * CW'(93);
    ge[1] = ys >= CW'(ax1) * CW'(215);
    ge[2] = ys >= CW'(ax1) * CW'(443);
    ge[3] = ys >= CW'(ax1) * CW'(1452);
    s_c   = 3'(ge[0]) + 3'(ge[1]) + 3'(ge[2]) + 3'(ge[3]);
    if (ax1 == '0 && ay1 == '0)     b_c = 4'd0;  // zero vector would otherwise read as vertical
    else if (!xneg1 || s_c == 3'd4) b_c = 4'(s_c);
    else                            b_c = 4'd8 - 4'(s_c);
    bin_c = (SIGNED_ORIENT != 0 && h1) ? 5'(b_c) + 5'd9 : 5'(b_c);

    a_c     = MW'(ax1);
    y_c     = MW'(ay1);
    mx      = (a_c >= y_c) ? a_c : y_c;
    mn      = (a_c >= y_c) ? y_c : a_c;
    mag_raw = (MAG_MODE == 0) ? a_c + y_c : mx + (mn >> 1);
    sat_c   = mag_raw > MAG_MAX;
    mag_c   = sat_c ? DATA_WIDTH'(MAG_MAX) : DATA_WIDTH'(mag_raw);
  end

  logic [DATA_WIDTH-1:0] mag2;
  logic [4:0]            bin2;
  logic                  sat2, last2;

  // Stage-2 register; a surviving border pixel is the frame-end token and carries no vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag2  <= '0;
      bin2  <= '0;
      sat2  <= 1'b0;
      last2 <= 1'b0;
    end else if (en) begin
      mag2  <= brd1 ? '0   : mag_c;
      bin2  <= brd1 ? '0   : bin_c;
      sat2  <= brd1 ? 1'b0 : sat_c;
      last2 <= last1;
    end
  end

  // ---------------- stage 3: output register ----------------
  // Held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_mag  <= '0;
      bus.out_bin  <= '0;
      bus.out_sat  <= 1'b0;
      bus.out_last <= 1'b0;
    end else if (en) begin
      bus.out_mag  <= mag2;
      bus.out_bin  <= bin2;
      bus.out_sat  <= sat2;
      bus.out_last <= last2;
    end
  end
endmodule
